// File: rtl/alu_exec_stage_pkg.sv
// alu_exec_stage_pkg: ALU opcodes, op-class helpers and processor-flag slot positions
`ifndef ALU_INOUT_WIDTH
`define ALU_INOUT_WIDTH 8
`endif
`ifndef PROC_FLAGS_WIDTH
`define PROC_FLAGS_WIDTH 4
`endif

package pkg_pflags;
    localparam int pf_slot_c = 0;
    localparam int pf_slot_z = 1;
    localparam int pf_slot_n = 2;
    localparam int pf_slot_v = 3;
endpackage

package pkg_alu;
    typedef enum logic [3:0] {
        alu_add, alu_adc, alu_sub, alu_sbc, alu_cmp, alu_and,
        alu_or, alu_xor, alu_rol, alu_ror, alu_rolc, alu_rorc
    } alu_op;

    function automatic logic alu_op_writes_reg(alu_op op);
        return op != alu_cmp;
    endfunction

    function automatic logic alu_op_uses_carry(alu_op op);
        return op inside {alu_adc, alu_sbc, alu_rolc, alu_rorc};
    endfunction
endpackage

// File: rtl/alu.sv
// alu: combinational ALU
//   in : oper, a, b, proc_flags_in (C is the carry/borrow-in)
//   out: out, proc_flags_out (C = carry or borrow, Z, N, V; other slots pass through)
`ifndef ALU_INOUT_WIDTH
`define ALU_INOUT_WIDTH 8
`endif
`ifndef PROC_FLAGS_WIDTH
`define PROC_FLAGS_WIDTH 4
`endif

module alu
    import pkg_alu::*;
    import pkg_pflags::*;
(
    input  alu_op                        oper,
    input  logic [`ALU_INOUT_WIDTH-1:0]  a,
    input  logic [`ALU_INOUT_WIDTH-1:0]  b,
    input  logic [`PROC_FLAGS_WIDTH-1:0] proc_flags_in,
    output logic [`ALU_INOUT_WIDTH-1:0]  out,
    output logic [`PROC_FLAGS_WIDTH-1:0] proc_flags_out
);
    localparam int W = `ALU_INOUT_WIDTH;
    logic cin, c, v;
    logic [1:0] n;
    logic [W:0] sum, dif;
    logic [2*W-1:0] rl, rr;
    logic [2*W+1:0] rlc, rrc;
    assign cin = alu_op_uses_carry(oper) && proc_flags_in[pf_slot_c];
    assign n = b[1:0];
    assign sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    // top bit of dif is the borrow out
    assign dif = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin};
    // rotates done on a doubled copy so the wrapped bits fall into the window
    assign rl = {a, a} << n;
    assign rr = {a, a} >> n;
    assign rlc = {cin, a, cin, a} << n;
    assign rrc = {cin, a, cin, a} >> n;
    always_comb begin
        c = proc_flags_in[pf_slot_c];
        v = 1'b0;
        out = a;
        case (oper)
            alu_add, alu_adc: begin
                {c, out} = sum;
                v = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
            end
            alu_sub, alu_sbc, alu_cmp: begin
                {c, out} = dif;
                v = (a[W-1] != b[W-1]) && (dif[W-1] != a[W-1]);
            end
            alu_and:  out = a & b;
            alu_or:   out = a | b;
            alu_xor:  out = a ^ b;
            alu_rol:  out = rl[2*W-1:W];
            alu_ror:  out = rr[W-1:0];
            alu_rolc: {c, out} = rlc[2*W+1:W+1];
            alu_rorc: {c, out} = rrc[W:0];
            default: ;
        endcase
    end
    always_comb begin
        proc_flags_out = proc_flags_in;
        proc_flags_out[pf_slot_c] = c;
        proc_flags_out[pf_slot_z] = out == '0;
        proc_flags_out[pf_slot_n] = out[W-1];
        proc_flags_out[pf_slot_v] = v;
    end
endmodule

// File: rtl/alu_regfile.sv
// alu_regfile: NUM_REGS x WIDTH register file, async clear
//   2 combinational read ports (rd_a, rd_b), 1 combinational debug read, 1 sync write port
`ifndef ALU_INOUT_WIDTH
`define ALU_INOUT_WIDTH 8
`endif

module alu_regfile #(
    parameter int NUM_REGS  = 16,
    parameter int REG_IDX_W = $clog2(NUM_REGS),
    parameter int WIDTH     = `ALU_INOUT_WIDTH
) (
    input  logic                 master_clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] wr_idx,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic [REG_IDX_W-1:0] rd_a_idx,
    input  logic [REG_IDX_W-1:0] rd_b_idx,
    input  logic [REG_IDX_W-1:0] dbg_idx,
    output logic [WIDTH-1:0]     rd_a_data,
    output logic [WIDTH-1:0]     rd_b_data,
    output logic [WIDTH-1:0]     dbg_data
);
    logic [WIDTH-1:0] regs [NUM_REGS];
    assign rd_a_data = regs[rd_a_idx];
    assign rd_b_data = regs[rd_b_idx];
    assign dbg_data = regs[dbg_idx];
    always_ff @(posedge master_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (we) begin
            regs[wr_idx] <= wr_data;
        end
    end
endmodule

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: execute/writeback stage around one alu with operand and carry bypass
//   in : master_clk, reset, in_valid/in_oper/in_ra/in_rb/in_use_imm/in_imm, hold, dbg_idx
//   out: in_ready, wb_valid/wb_we/wb_idx/wb_data, proc_flags, dbg_data
`ifndef ALU_INOUT_WIDTH
`define ALU_INOUT_WIDTH 8
`endif
`ifndef PROC_FLAGS_WIDTH
`define PROC_FLAGS_WIDTH 4
`endif

module alu_exec_stage
    import pkg_alu::*;
    import pkg_pflags::*;
#(
    parameter int NUM_REGS  = 16,
    parameter int REG_IDX_W = $clog2(NUM_REGS)
) (
    input  logic                          master_clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  alu_op                         in_oper,
    input  logic [REG_IDX_W-1:0]          in_ra,
    input  logic [REG_IDX_W-1:0]          in_rb,
    input  logic                          in_use_imm,
    input  logic [`ALU_INOUT_WIDTH-1:0]   in_imm,
    input  logic                          hold,
    output logic                          wb_valid,
    output logic                          wb_we,
    output logic [REG_IDX_W-1:0]          wb_idx,
    output logic [`ALU_INOUT_WIDTH-1:0]   wb_data,
    output logic [`PROC_FLAGS_WIDTH-1:0]  proc_flags,
    input  logic [REG_IDX_W-1:0]          dbg_idx,
    output logic [`ALU_INOUT_WIDTH-1:0]   dbg_data
);
    localparam int W = `ALU_INOUT_WIDTH;
    localparam int FW = `PROC_FLAGS_WIDTH;
    logic ex_valid, fwd;
    alu_op ex_oper;
    logic [REG_IDX_W-1:0] ex_ra;
    logic [W-1:0] ex_a, ex_b, alu_out, rd_a, rd_b, op_a, op_b;
    // ex_flags[pf_slot_c] is the carry-in latched at accept
    logic [FW-1:0] ex_flags, alu_flags, flags_next;
    assign in_ready = !hold;
    // the op in EX writes back at the same edge the next op is accepted, so forward its result
    assign fwd = ex_valid && alu_op_writes_reg(ex_oper);
    assign op_a = (fwd && ex_ra == in_ra) ? alu_out : rd_a;
    assign op_b = in_use_imm ? in_imm : ((fwd && ex_ra == in_rb) ? alu_out : rd_b);
    assign flags_next = ex_valid ? alu_flags : proc_flags;
    alu_regfile #(.NUM_REGS(NUM_REGS), .REG_IDX_W(REG_IDX_W), .WIDTH(W)) u_regfile (
        .master_clk(master_clk),
        .reset(reset),
        .we(fwd && !hold),
        .wr_idx(ex_ra),
        .wr_data(alu_out),
        .rd_a_idx(in_ra),
        .rd_b_idx(in_rb),
        .dbg_idx(dbg_idx),
        .rd_a_data(rd_a),
        .rd_b_data(rd_b),
        .dbg_data(dbg_data)
    );
    alu u_alu (
        .oper(ex_oper),
        .a(ex_a),
        .b(ex_b),
        .proc_flags_in(ex_flags),
        .out(alu_out),
        .proc_flags_out(alu_flags)
    );
    always_ff @(posedge master_clk or posedge reset) begin
        if (reset) begin
            ex_valid <= 1'b0;
            ex_oper <= alu_add;
            ex_ra <= '0;
            ex_a <= '0;
            ex_b <= '0;
            ex_flags <= '0;
            wb_valid <= 1'b0;
            wb_we <= 1'b0;
            wb_idx <= '0;
            wb_data <= '0;
            proc_flags <= '0;
        end else if (!hold) begin
            ex_valid <= in_valid;
            if (in_valid) begin
                ex_oper <= in_oper;
                ex_ra <= in_ra;
                ex_a <= op_a;
                ex_b <= op_b;
                ex_flags <= flags_next;
            end
            wb_valid <= ex_valid;
            wb_we <= fwd;
            if (ex_valid) begin
                wb_idx <= ex_ra;
                wb_data <= alu_out;
                proc_flags <= alu_flags;
            end
        end
    end
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: in-order ISA model plus one-cycle writeback delay, checked every cycle
`ifndef ALU_INOUT_WIDTH
`define ALU_INOUT_WIDTH 8
`endif
`ifndef PROC_FLAGS_WIDTH
`define PROC_FLAGS_WIDTH 4
`endif

module tb_alu_exec_stage;
    import pkg_alu::*;
    logic master_clk = 0;
    logic reset = 1;
    logic in_valid = 0;
    logic in_use_imm = 0;
    logic hold = 0;
    alu_op in_oper = alu_add;
    logic [3:0] in_ra = 0, in_rb = 0, dbg_idx = 0;
    logic [7:0] in_imm = 0;
    logic in_ready, wb_valid, wb_we;
    logic [3:0] wb_idx, proc_flags;
    logic [7:0] wb_data, dbg_data;
    int tests = 0;
    int fails = 0;
    bit started = 0;

    alu_exec_stage #(.NUM_REGS(16)) dut (
        .master_clk(master_clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_oper(in_oper), .in_ra(in_ra), .in_rb(in_rb), .in_use_imm(in_use_imm), .in_imm(in_imm),
        .hold(hold), .wb_valid(wb_valid), .wb_we(wb_we), .wb_idx(wb_idx), .wb_data(wb_data),
        .proc_flags(proc_flags), .dbg_idx(dbg_idx), .dbg_data(dbg_data)
    );

    always #5 master_clk = ~master_clk;

    // reference op semantics, flags packed {V,N,Z,C}, result in low byte
    function automatic logic [11:0] ref_alu(alu_op op, logic [7:0] a, logic [7:0] b, logic [3:0] f);
        int s, ss, ci;
        logic [7:0] r;
        logic c, v, t;
        ci = (op inside {alu_adc, alu_sbc} && f[0]) ? 1 : 0;
        r = a;
        c = f[0];
        v = 0;
        case (op)
            alu_add, alu_adc: begin
                s = int'(a) + int'(b) + ci;
                ss = int'($signed(a)) + int'($signed(b)) + ci;
                r = s[7:0];
                c = s > 255;
                v = ss > 127 || ss < -128;
            end
            alu_sub, alu_sbc, alu_cmp: begin
                s = int'(a) - int'(b) - ci;
                ss = int'($signed(a)) - int'($signed(b)) - ci;
                r = s[7:0];
                c = s < 0;
                v = ss > 127 || ss < -128;
            end
            alu_and: r = a & b;
            alu_or:  r = a | b;
            alu_xor: r = a ^ b;
            alu_rol:  for (int i = 0; i < int'(b[1:0]); i++) r = {r[6:0], r[7]};
            alu_ror:  for (int i = 0; i < int'(b[1:0]); i++) r = {r[0], r[7:1]};
            alu_rolc: for (int i = 0; i < int'(b[1:0]); i++) begin t = r[7]; r = {r[6:0], c}; c = t; end
            alu_rorc: for (int i = 0; i < int'(b[1:0]); i++) begin t = r[0]; r = {c, r[7:1]}; c = t; end
            default: ;
        endcase
        return {v, r[7], r == 8'h00, c, r};
    endfunction

    // m_* = architectural state after every accepted op; c_* = state visible after writeback
    logic [7:0] m_regs [16];
    logic [7:0] c_regs [16];
    logic [3:0] m_flags = 0, c_flags = 0, pend_flags = 0;
    logic pend_v = 0, pend_we = 0, e_wb_valid = 0, e_we = 0;
    logic [3:0] pend_idx = 0, e_idx = 0;
    logic [7:0] pend_data = 0, e_data = 0;
    logic [11:0] m_res;
    assign m_res = ref_alu(in_oper, m_regs[in_ra], in_use_imm ? in_imm : m_regs[in_rb], m_flags);

    always @(posedge master_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                m_regs[i] <= 0;
                c_regs[i] <= 0;
            end
            m_flags <= 0;
            c_flags <= 0;
            pend_v <= 0;
            e_wb_valid <= 0;
            e_we <= 0;
            e_idx <= 0;
            e_data <= 0;
        end else if (!hold) begin
            e_wb_valid <= pend_v;
            e_we <= pend_v && pend_we;
            if (pend_v) begin
                e_idx <= pend_idx;
                e_data <= pend_data;
                c_flags <= pend_flags;
                if (pend_we) c_regs[pend_idx] <= pend_data;
            end
            pend_v <= in_valid;
            if (in_valid) begin
                pend_idx <= in_ra;
                pend_data <= m_res[7:0];
                pend_flags <= m_res[11:8];
                pend_we <= in_oper != alu_cmp;
                if (in_oper != alu_cmp) m_regs[in_ra] <= m_res[7:0];
                m_flags <= m_res[11:8];
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge master_clk) begin
        if (started && !reset) begin
            chk("wb_valid", wb_valid, e_wb_valid);
            chk("wb_we", wb_we, e_we);
            chk("wb_idx", wb_idx, e_idx);
            chk("wb_data", wb_data, e_data);
            chk("proc_flags", proc_flags, c_flags);
            chk("in_ready", in_ready, !hold);
            chk("dbg_data", dbg_data, c_regs[dbg_idx]);
        end
    end

    task automatic step();
        @(posedge master_clk);
        #1;
    endtask

    task automatic opi(input alu_op op, input logic [3:0] ra, input logic [7:0] imm);
        in_valid = 1; in_oper = op; in_ra = ra; in_rb = 0; in_use_imm = 1; in_imm = imm;
        step();
        in_valid = 0;
    endtask

    task automatic opr(input alu_op op, input logic [3:0] ra, input logic [3:0] rb);
        in_valid = 1; in_oper = op; in_ra = ra; in_rb = rb; in_use_imm = 0; in_imm = 8'h00;
        step();
        in_valid = 0;
    endtask

    task automatic expect_reg(input logic [3:0] i, input logic [7:0] v);
        dbg_idx = i;
        #1;
        chk($sformatf("dbg_r%0d", i), dbg_data, v);
        chk($sformatf("model_r%0d", i), c_regs[i], v);
    endtask

    initial begin
        repeat (2) @(posedge master_clk);
        #1;
        reset = 0;
        started = 1;
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_wb_we", wb_we, 1'b0);
        chk("rst_flags", proc_flags, 4'h0);
        chk("rst_in_ready", in_ready, 1'b1);
        for (int i = 0; i < 16; i++) expect_reg(4'(i), 8'h00);
        step();

        // immediate chain through the A bypass
        opi(alu_add, 1, 8'h7F);
        opi(alu_add, 1, 8'h01);
        step();
        expect_reg(1, 8'h80);
        chk("chain_flags", proc_flags, 4'hC);
        step();

        // carry chain: add sets C, adc consumes it in the very next cycle
        opi(alu_add, 2, 8'hFF);
        opi(alu_add, 2, 8'h01);
        opi(alu_adc, 3, 8'h00);
        chk("carry_wb_data", wb_data, 8'h00);
        chk("carry_wb_idx", wb_idx, 4'd2);
        chk("carry_flags", proc_flags, 4'h3);
        step();
        chk("adc_wb_data", wb_data, 8'h01);
        expect_reg(2, 8'h00);
        expect_reg(3, 8'h01);
        step();

        // cmp updates flags but not the register file
        opi(alu_add, 4, 8'h10);
        opi(alu_cmp, 4, 8'h10);
        step();
        chk("cmp_wb_valid", wb_valid, 1'b1);
        chk("cmp_wb_we", wb_we, 1'b0);
        chk("cmp_wb_idx", wb_idx, 4'd4);
        chk("cmp_flags", proc_flags, 4'h2);
        expect_reg(4, 8'h10);
        step();

        // hold freezes EX and writeback; an offered op must not be taken
        opi(alu_add, 5, 8'h05);
        step();
        opi(alu_sub, 5, 8'h01);
        hold = 1;
        in_valid = 1; in_oper = alu_xor; in_ra = 5; in_use_imm = 1; in_imm = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("hold_in_ready", in_ready, 1'b0);
            chk("hold_wb_valid", wb_valid, 1'b0);
            expect_reg(5, 8'h05);
        end
        in_valid = 0;
        hold = 0;
        step();
        chk("release_wb_valid", wb_valid, 1'b1);
        chk("release_wb_data", wb_data, 8'h04);
        expect_reg(5, 8'h04);
        step();

        // rotate through carry with bypassed C
        opi(alu_add, 6, 8'h81);
        opi(alu_cmp, 0, 8'h01);
        opi(alu_rolc, 6, 8'h01);
        opi(alu_rorc, 6, 8'h01);
        chk("rolc_wb_data", wb_data, 8'h03);
        chk("rolc_wb_idx", wb_idx, 4'd6);
        chk("rolc_flags", proc_flags, 4'h1);
        step();
        chk("rorc_wb_data", wb_data, 8'h81);
        chk("rorc_flags", proc_flags, 4'h5);
        expect_reg(6, 8'h81);
        step();

        // register B operands, B bypass, shift amount from B[1:0], src == dst
        opr(alu_or, 9, 1);
        opi(alu_ror, 9, 8'h05);
        opr(alu_and, 9, 9);
        opr(alu_sbc, 10, 9);
        opr(alu_xor, 11, 10);
        opi(alu_rol, 11, 8'h02);
        chk("rol_src_wb", wb_data, 8'hBF);
        opr(alu_sub, 11, 11);
        chk("rol_wb_data", wb_data, 8'hFE);
        step();
        expect_reg(9, 8'h40);
        expect_reg(10, 8'hBF);
        expect_reg(11, 8'h00);
        step();

        // reset with an op in EX discards it
        opi(alu_add, 1, 8'h01);
        #1;
        reset = 1;
        #1;
        chk("rst_mid_wb_valid", wb_valid, 1'b0);
        chk("rst_mid_flags", proc_flags, 4'h0);
        expect_reg(1, 8'h00);
        step();
        reset = 0;
        step();
        chk("post_rst_wb_valid", wb_valid, 1'b0);
        for (int i = 0; i < 16; i++) expect_reg(4'(i), 8'h00);
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
